relu_bwd_ctrl: RTL

Sequencer for the ReLU stage of the adapter's backward pass. During the forward pass it records one "clamped" bit per activation, using the sign and exception bits of the 18-bit FloPoCo pre-activation. During the backward pass it streams incoming gradients through in the same order, forwarding a gradient where the activation was positive and substituting FloPoCo zero where it was clamped. It sits between the adapter's forward activation stream and the gradient path feeding the weight-update multipliers.

---
 rtl/relu_bwd_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/relu_bwd_ctrl.sv
// relu_bwd_ctrl: sequencer for the ReLU stage of the adapter's backward pass.
// A forward capture records one clamped bit per activation.
// A backward pass then streams gradients through in the same order,
// zeroing those whose activation was clamped.
// Optional build macro: RELU_BWD_PASS_NAN_EN. When it is defined, a NaN gradient is
// forwarded unchanged even at a clamped position, so numeric faults stay visible.

module relu_bwd_ctrl #(
   parameter int BITWIDTH = 16,
   parameter int DEPTH    = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_fwd,
   input  logic                       start_bwd,
   input  logic [$clog2(DEPTH+1)-1:0] len,
   input  logic                       fwd_valid,
   output logic                       fwd_ready,
   input  logic [BITWIDTH+1:0]        fwd_data,
   input  logic                       bwd_in_valid,
   output logic                       bwd_in_ready,
   input  logic [BITWIDTH+1:0]        bwd_in_data,
   output logic                       bwd_out_valid,
   input  logic                       bwd_out_ready,
   output logic [BITWIDTH+1:0]        bwd_out_data,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   localparam int LW = $clog2(DEPTH+1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DW = BITWIDTH + 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_BACKWARD,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [LW-1:0]    idx;
   logic [LW-1:0]    len_q;
   logic [LW-1:0]    mask_len;
   logic             mask_valid;
   logic [DEPTH-1:0] mask;
   logic             out_valid;
   logic [DW-1:0]    out_data;
   logic             err_q;

   logic             fwd_fire;
   logic             bwd_in_fire;
   logic             last_beat;
   logic             len_too_big;
   logic             bwd_reject;
   logic             fwd_clamped;
   logic             grad_zeroed;
   logic [DW-1:0]    grad_gated;
   logic             unused_fwd_bits;

   // Only the exception field and the sign bit decide clamping.
   assign unused_fwd_bits = ^fwd_data[BITWIDTH-2:0];

   // Clamp classification of the incoming pre-activation and gating of the incoming gradient.
   always_comb begin
      fwd_clamped = (fwd_data[DW-1:DW-2] == 2'b00) ||
                    (fwd_data[DW-1:DW-2] == 2'b11) ||
                    fwd_data[BITWIDTH-1];
`ifdef RELU_BWD_PASS_NAN_EN
      grad_zeroed = mask[idx[IW-1:0]] && (bwd_in_data[DW-1:DW-2] != 2'b11);
`else
      grad_zeroed = mask[idx[IW-1:0]];
`endif
      grad_gated  = grad_zeroed ? '0 : bwd_in_data;
   end

   // Handshakes, start qualification, outputs derived from state, and next-state selection.
   always_comb begin
      fwd_ready     = 1'b0;
      bwd_in_ready  = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      state_nxt     = state;

      fwd_ready     = (state == S_CAPTURE);
      bwd_in_ready  = (state == S_BACKWARD) && (!out_valid || bwd_out_ready);
      busy          = (state != S_IDLE);
      done          = (state == S_DONE);

      fwd_fire      = fwd_valid && fwd_ready;
      bwd_in_fire   = bwd_in_valid && bwd_in_ready;
      last_beat     = ((idx + LW'(1)) == len_q);
      len_too_big   = (len > LW'(DEPTH));
      bwd_reject    = len_too_big || !mask_valid || (len != mask_len);

      case (state)
         S_IDLE: begin
            if (start_fwd) begin
               state_nxt = (len_too_big || len == '0) ? S_DONE : S_CAPTURE;
            end else if (start_bwd) begin
               state_nxt = (bwd_reject || len == '0) ? S_DONE : S_BACKWARD;
            end
         end
         S_CAPTURE: begin
            if (fwd_fire && last_beat) state_nxt = S_DONE;
         end
         S_BACKWARD: begin
            if (bwd_in_fire && last_beat) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (!out_valid || bwd_out_ready) state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register; reset aborts any pass immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Pass bookkeeping: element index, pass length, mask validity, sticky error, output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx        <= '0;
         len_q      <= '0;
         mask_len   <= '0;
         mask_valid <= 1'b0;
         err_q      <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_fwd) begin
                  err_q <= len_too_big;
                  idx   <= '0;
                  len_q <= len;
                  if (!len_too_big) begin
                     mask_valid <= (len == '0);
                     mask_len   <= '0;
                  end
               end else if (start_bwd) begin
                  err_q <= bwd_reject;
                  idx   <= '0;
                  len_q <= len;
               end
            end
            S_CAPTURE: begin
               if (fwd_fire) begin
                  idx <= idx + LW'(1);
                  if (last_beat) begin
                     mask_valid <= 1'b1;
                     mask_len   <= len_q;
                  end
               end
            end
            S_BACKWARD: begin
               if (bwd_in_fire) idx <= idx + LW'(1);
            end
            default: begin
            end
         endcase

         if (bwd_in_fire) begin
            out_valid <= 1'b1;
            out_data  <= grad_gated;
         end else if (out_valid && bwd_out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Mask storage is deliberately left unreset; mask_valid alone says whether it is usable.
   always_ff @(posedge clk) begin
      if (fwd_fire) mask[idx[IW-1:0]] <= fwd_clamped;
   end

   assign bwd_out_valid = out_valid;
   assign bwd_out_data  = out_data;
   assign err           = err_q;

endmodule
